// File: rtl/tgt_pkg.sv
// ---------------------------------------------------------------------------
// tgt_pkg
// Shared definitions for the data RAM target and its response buffer.
//   rsp_t         : one buffered response (read error, write error, data)
//   PRIV_*        : requester privilege encodings; PRIV_USER is the only
//                   level barred from the protected low words
//   RSP_NONE      : idle/cleared response value
// ---------------------------------------------------------------------------
package tgt_pkg;

   localparam logic [1:0] PRIV_USER    = 2'b00;
   localparam logic [1:0] PRIV_SUPER   = 2'b01;
   localparam logic [1:0] PRIV_MACHINE = 2'b11;

   typedef struct packed {
      logic        rerr;
      logic        werr;
      logic [31:0] data;
   } rsp_t;

   localparam rsp_t RSP_NONE = '0;

endpackage

// File: rtl/rsp_fifo.sv
// ---------------------------------------------------------------------------
// rsp_fifo
// Two-entry in-order response buffer. Each accepted request pushes exactly
// one response; the head is presented until the requester takes it.
// Ports:
//   clk, reset  : clock, asynchronous active-high reset (empties the buffer)
//   push        : store push_data at the tail this cycle
//   push_data   : response to store
//   pop         : head was consumed this cycle (ignored when empty)
//   head        : oldest response, forced to zero while empty
//   valid       : buffer holds at least one response
//   count       : number of buffered responses, 0..2
// ---------------------------------------------------------------------------
module rsp_fifo
   import tgt_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  rsp_t       push_data,
   input  logic       pop,
   output rsp_t       head,
   output logic       valid,
   output logic [1:0] count
);

   rsp_t       entries [2];
   logic       wr_ptr;
   logic       rd_ptr;
   logic [1:0] count_q;
   logic       pop_ok;

   assign valid  = (count_q != 2'd0);
   assign pop_ok = pop & valid;

   // Pointers and occupancy. The parent never pushes while full unless it
   // pops in the same cycle, so no overflow guard is needed here. Entries
   // are cleared on reset so nothing stale can ever be presented.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= 1'b0;
         rd_ptr     <= 1'b0;
         count_q    <= 2'd0;
         entries[0] <= RSP_NONE;
         entries[1] <= RSP_NONE;
      end else begin
         if (push) begin
            entries[wr_ptr] <= push_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop_ok) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop_ok})
            2'b10:   count_q <= count_q + 2'd1;
            2'b01:   count_q <= count_q - 2'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Head only changes when popped, which keeps the response stable while
   // the requester stalls. Zero while empty so the outputs idle at zero.
   assign head  = valid ? entries[rd_ptr] : RSP_NONE;
   assign count = count_q;

endmodule

// File: rtl/data_ram_tgt.sv
// ---------------------------------------------------------------------------
// data_ram_tgt
// Word-addressed 32-bit data RAM behind a valid/ready request channel and a
// valid/ready response channel, with up to two requests outstanding.
// Requests are decoded and executed in the cycle they are accepted; the
// result is queued in rsp_fifo and appears on the response channel the
// following cycle, in request order.
// Parameters:
//   C_BASE_ADDR  : byte address of word 0
//   C_DEPTH      : number of 32-bit words (power of two)
//   C_PROT_WORDS : number of low words user privilege may not touch
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   treqready    : registered; target accepts a request this cycle
//   treqvalid    : request valid
//   treqpriv     : requester privilege (2'b00 = user)
//   treqaddr     : byte address
//   treqwen      : 1 = write, 0 = read
//   treqben      : write byte enables
//   treqdata     : write data
//   trspready    : requester takes the response this cycle
//   trspvalid    : response valid
//   trsprerr     : read error
//   trspwerr     : write error
//   trspdata     : read data (zero on writes and errors)
// ---------------------------------------------------------------------------
module data_ram_tgt
   import tgt_pkg::*;
#(
   parameter logic [31:0] C_BASE_ADDR  = 32'h0001_0000,
   parameter int          C_DEPTH      = 1024,
   parameter int          C_PROT_WORDS = 64
)
(
   input  logic        clk,
   input  logic        reset,
   output logic        treqready,
   input  logic        treqvalid,
   input  logic [1:0]  treqpriv,
   input  logic [31:0] treqaddr,
   input  logic        treqwen,
   input  logic [3:0]  treqben,
   input  logic [31:0] treqdata,
   input  logic        trspready,
   output logic        trspvalid,
   output logic        trsprerr,
   output logic        trspwerr,
   output logic [31:0] trspdata
);

   localparam int          AW         = (C_DEPTH > 1) ? $clog2(C_DEPTH) : 1;
   localparam logic [32:0] SPAN_BYTES = 33'(C_DEPTH) << 2;
   localparam logic [31:0] PROT_LIMIT = 32'(C_PROT_WORDS);

   logic [31:0]   mem [C_DEPTH];

   logic          ready_q;
   logic          req_fire;
   logic          rsp_fire;
   logic [31:0]   offset;
   logic [31:0]   word_off;
   logic          misaligned;
   logic          out_of_range;
   logic          priv_fault;
   logic          req_err;
   logic [AW-1:0] idx;
   rsp_t          rsp_new;
   rsp_t          rsp_head;
   logic          rsp_valid;
   logic [1:0]    count;
   logic [1:0]    count_next;

   assign treqready = ready_q;
   assign req_fire  = treqvalid & ready_q;
   assign rsp_fire  = rsp_valid & trspready;

   // Address decode. The range test uses a 33-bit compare so a window that
   // ends at the top of the address space cannot wrap. The word index is
   // only meaningful once the range test has passed.
   always_comb begin
      offset       = treqaddr - C_BASE_ADDR;
      word_off     = offset >> 2;
      misaligned   = |treqaddr[1:0];
      out_of_range = (treqaddr < C_BASE_ADDR) || ({1'b0, offset} >= SPAN_BYTES);
      priv_fault   = (treqpriv == PRIV_USER) && (word_off < PROT_LIMIT);
      req_err      = misaligned | out_of_range | priv_fault;
      idx          = word_off[AW-1:0];
   end

   // Response for the request being presented. Reads sample the array as it
   // stands now, which already includes any write accepted on an earlier
   // edge, so read-after-write needs no forwarding path.
   always_comb begin
      rsp_new = RSP_NONE;
      if (req_err) begin
         rsp_new.rerr = ~treqwen;
         rsp_new.werr = treqwen;
      end else if (!treqwen) begin
         rsp_new.data = mem[idx];
      end
   end

   // Storage array. Deliberately not reset so contents survive a reset.
   // Requests cannot fire during reset because treqready is held low.
   always_ff @(posedge clk) begin
      if (req_fire && treqwen && !req_err) begin
         for (int b = 0; b < 4; b++) begin
            if (treqben[b]) begin
               mem[idx][8*b +: 8] <= treqdata[8*b +: 8];
            end
         end
      end
   end

   // Occupancy after this edge; a simultaneous accept and retire cancel.
   always_comb begin
      case ({req_fire, rsp_fire})
         2'b10:   count_next = count + 2'd1;
         2'b01:   count_next = count - 2'd1;
         default: count_next = count;
      endcase
   end

   // Registered ready: open whenever fewer than two responses will be
   // owed after this edge, so a full buffer that is being drained reopens
   // in the same cycle the slot frees up.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ready_q <= 1'b0;
      end else begin
         ready_q <= (count_next != 2'd2);
      end
   end

   rsp_fifo u_rsp_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (req_fire),
      .push_data (rsp_new),
      .pop       (rsp_fire),
      .head      (rsp_head),
      .valid     (rsp_valid),
      .count     (count)
   );

   assign trspvalid = rsp_valid;
   assign trsprerr  = rsp_head.rerr;
   assign trspwerr  = rsp_head.werr;
   assign trspdata  = rsp_head.data;

endmodule

// File: doc/data_ram_tgt.md
DATA_RAM_TGT -- requirements
Module: data_ram_tgt

Interface
REQ-001 SHALL have parameter C_BASE_ADDR, default 32'h0001_0000, byte address of word 0.
REQ-002 SHALL have parameter C_DEPTH, default 1024, number of 32-bit words; power of two.
REQ-003 SHALL have parameter C_PROT_WORDS, default 64, number of low words that user privilege may not access.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 treqready  out  1  target can accept a request this cycle.
REQ-007 treqvalid  in  1  request valid.
REQ-008 treqpriv  in  2  privilege level of the requester; 2'b00 = user.
REQ-009 treqaddr  in  32  byte address.
REQ-010 treqwen  in  1  1 = write, 0 = read.
REQ-011 treqben  in  4  byte enables for writes; ignored on reads.
REQ-012 treqdata  in  32  write data.
REQ-013 trspready  in  1  requester accepts a response this cycle.
REQ-014 trspvalid  out  1  response valid.
REQ-015 trsprerr  out  1  read error.
REQ-016 trspwerr  out  1  write error.
REQ-017 trspdata  out  32  read data; 0 on writes and errors.

Function
REQ-018 Request handshake SHALL complete when treqvalid and treqready are both 1; response handshake SHALL complete when trspvalid and trspready are both 1.
REQ-019 outstanding SHALL count requests accepted but not yet answered, range 0..2; +1 per request handshake, -1 per response handshake, unchanged when both occur in the same cycle.
REQ-020 treqready SHALL be 1 exactly when outstanding < 2 and reset is low; it SHALL be a registered output.
REQ-021 A request accepted in cycle N SHALL make its response available no earlier than cycle N+1, and exactly at N+1 when no earlier response is pending.
REQ-022 Responses SHALL be returned strictly in request order.
REQ-023 Back-to-back requests with trspready held 1 SHALL sustain one request and one response per cycle.
REQ-024 A request SHALL be in error when addr[1:0] != 0, when addr is outside [C_BASE_ADDR, C_BASE_ADDR + 4*C_DEPTH), or when treqpriv == 2'b00 and word offset < C_PROT_WORDS.
REQ-025 An erroneous read SHALL respond with trsprerr=1, trspwerr=0, trspdata=0.
REQ-026 An erroneous write SHALL respond with trspwerr=1, trsprerr=0, and SHALL NOT modify memory.
REQ-027 A valid write SHALL update only the bytes whose treqben bit is 1, and SHALL respond with both error flags 0 and trspdata=0.
REQ-028 A valid read SHALL return the word as it stands after all earlier-accepted writes, including a write accepted in the immediately preceding cycle.
REQ-029 Word index SHALL be (addr - C_BASE_ADDR) >> 2, truncated to log2(C_DEPTH) bits after the range check.
REQ-030 While trspvalid=1 and trspready=0, trspvalid, trsprerr, trspwerr and trspdata SHALL hold stable.

Reset
REQ-031 While reset is high: treqready=0, trspvalid=0, trsprerr=0, trspwerr=0, trspdata=0, outstanding=0, response buffer empty.
REQ-032 Asserting reset mid-operation SHALL discard all in-flight requests and buffered responses; no response for them SHALL ever appear.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 treqready SHALL rise in the first clock edge after reset deasserts.

Structure
REQ-035 Shared package tgt_pkg SHALL hold the response struct type (rerr, werr, data) and the privilege encoding constants (user=2'b00).
REQ-036 The 2-entry in-order response buffer SHALL be a sub-module named rsp_fifo; the storage array and error decode SHALL be in data_ram_tgt.

Verification
REQ-037 Write 32'hDEAD_BEEF, ben 4'hF, to C_BASE_ADDR+16 (priv 2'b11), then read the same address -> read data 32'hDEAD_BEEF, no error flags.
REQ-038 Write 32'h1122_3344, ben 4'b0101, over 32'hDEAD_BEEF, then read -> data 32'hDE22_BE44.
REQ-039 Read C_BASE_ADDR+2, then read C_BASE_ADDR+4*C_DEPTH -> two responses with trsprerr=1 and data 0; memory unchanged.
REQ-040 Priv 2'b00 write to C_BASE_ADDR+4 -> trspwerr=1 and word unchanged; same write with priv 2'b11 -> no error.
REQ-041 Issue 4 back-to-back reads with trspready=0 -> treqready=0 after 2 accepts; release trspready -> 4 in-order responses; one request per cycle sustained with trspready=1.
REQ-042 Assert reset with outstanding=2 -> trspvalid=0 immediately; after release, no stale response appears and the next read completes normally.
